// File: rtl/im_boot_loader.sv
// Instruction-memory port sequencer: CPU fetch pass-through, or UART boot load of a
// little-endian image (16-bit word count, then 4 bytes per word). Optional: IM_LOAD_CHKSUM_EN.
module im_boot_loader #(
  parameter int          DEPTH   = 1024,
  parameter logic [23:0] TIMEOUT = 24'd5000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_start,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  input  logic [13:0] cpu_addr,
  input  logic        cpu_rd_en,
  output logic [13:0] im_addr,
  output logic        im_rd_en,
  output logic        im_wr_en,
  output logic [31:0] im_wdata,
  output logic        cpu_stall,
  output logic        load_done,
  output logic        load_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_WR,
`ifdef IM_LOAD_CHKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [16:0] LP_DEPTH = 17'(DEPTH);

  state_t      r_state, w_state_n;
  logic        r_clr;
  logic [1:0]  r_bcnt;
  logic [7:0]  r_hdr_lo;
  logic [15:0] r_n;
  logic [13:0] r_wptr;
  logic [23:0] r_tmo;
  logic [31:0] r_wdata;
  logic        r_done, r_err;
  logic        w_rx_state, w_take, w_tmo, w_last, w_bad_n;
  logic [15:0] w_n;
`ifdef IM_LOAD_CHKSUM_EN
  logic [7:0]  r_xor;
`endif

  // A byte is taken only once per rx_rdy assertion; r_clr masks the cycle the ack is out.
`ifdef IM_LOAD_CHKSUM_EN
  assign w_rx_state = (r_state == S_HDR) || (r_state == S_DATA) || (r_state == S_CHK);
`else
  assign w_rx_state = (r_state == S_HDR) || (r_state == S_DATA);
`endif
  assign w_take  = w_rx_state && rx_rdy && !r_clr;
  assign w_tmo   = w_rx_state && !w_take && (r_tmo == TIMEOUT - 24'd1);
  assign w_n     = {rx_data, r_hdr_lo};
  assign w_bad_n = (w_n == 16'd0) || ({1'b0, w_n} > LP_DEPTH);
  assign w_last  = ({2'b00, r_wptr} == r_n - 16'd1);

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_IDLE: if (ld_start) w_state_n = S_HDR;
      S_HDR: begin
        if (w_tmo) w_state_n = S_ERR;
        else if (w_take && r_bcnt == 2'd1) w_state_n = w_bad_n ? S_ERR : S_DATA;
      end
      S_DATA: begin
        if (w_tmo) w_state_n = S_ERR;
        else if (w_take && r_bcnt == 2'd3) w_state_n = S_WR;
      end
      S_WR: begin
`ifdef IM_LOAD_CHKSUM_EN
        w_state_n = w_last ? S_CHK : S_DATA;
`else
        w_state_n = w_last ? S_DONE : S_DATA;
`endif
      end
`ifdef IM_LOAD_CHKSUM_EN
      S_CHK: begin
        if (w_tmo) w_state_n = S_ERR;
        else if (w_take) w_state_n = (rx_data == r_xor) ? S_DONE : S_ERR;
      end
`endif
      S_DONE:  w_state_n = S_IDLE;
      S_ERR:   w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_clr    <= 1'b0;
      r_bcnt   <= 2'd0;
      r_hdr_lo <= 8'd0;
      r_n      <= 16'd0;
      r_wptr   <= 14'd0;
      r_tmo    <= 24'd0;
      r_wdata  <= 32'd0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_clr   <= w_take;
      if (r_state == S_IDLE) begin
        r_bcnt <= 2'd0;
        r_wptr <= 14'd0;
      end else if (w_take) begin
        r_bcnt <= (r_state == S_HDR && r_bcnt == 2'd1) ? 2'd0 : r_bcnt + 2'd1;
      end
      if (w_take && r_state == S_HDR && r_bcnt == 2'd0) r_hdr_lo <= rx_data;
      if (w_take && r_state == S_HDR && r_bcnt == 2'd1) r_n <= w_n;
      if (w_take && r_state == S_DATA) r_wdata[{r_bcnt, 3'b000} +: 8] <= rx_data;
      if (r_state == S_WR) r_wptr <= r_wptr + 14'd1;
      r_tmo <= (!w_rx_state || w_take) ? 24'd0 : r_tmo + 24'd1;
      // Status flags are set as DONE/ERR is entered so they are visible in that cycle.
      if (r_state == S_IDLE && ld_start) begin
        r_done <= 1'b0;
        r_err  <= 1'b0;
      end else begin
        if (w_state_n == S_DONE) r_done <= 1'b1;
        if (w_state_n == S_ERR)  r_err  <= 1'b1;
      end
    end
  end

`ifdef IM_LOAD_CHKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_xor <= 8'd0;
    end else if (r_state == S_IDLE) begin
      r_xor <= 8'd0;
    end else if (w_take && (r_state == S_HDR || r_state == S_DATA)) begin
      r_xor <= r_xor ^ rx_data;
    end
  end
`endif

  assign clr_rx_rdy = r_clr;
  assign im_addr    = (r_state == S_IDLE) ? cpu_addr : r_wptr;
  assign im_rd_en   = (r_state == S_IDLE) ? cpu_rd_en : 1'b0;
  assign im_wr_en   = (r_state == S_WR);
  assign im_wdata   = r_wdata;
  assign cpu_stall  = !((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));
  assign load_done  = r_done;
  assign load_err   = r_err;

endmodule

// File: tb/tb_im_boot_loader.sv
// Directed bench for im_boot_loader: pass-through, nominal load, bad header,
// byte timeout, reset mid-load, and (with IM_LOAD_CHKSUM_EN) checksum accept/reject.
module tb_im_boot_loader;

  localparam logic [23:0] TMO = 24'd300;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ld_start = 1'b0;
  logic        rx_rdy = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        clr_rx_rdy;
  logic [13:0] cpu_addr = 14'h0;
  logic        cpu_rd_en = 1'b0;
  logic [13:0] im_addr;
  logic        im_rd_en;
  logic        im_wr_en;
  logic [31:0] im_wdata;
  logic        cpu_stall;
  logic        load_done;
  logic        load_err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [13:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cnt = 0;

  im_boot_loader #(.DEPTH(1024), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .ld_start(ld_start), .rx_rdy(rx_rdy), .rx_data(rx_data),
    .clr_rx_rdy(clr_rx_rdy), .cpu_addr(cpu_addr), .cpu_rd_en(cpu_rd_en),
    .im_addr(im_addr), .im_rd_en(im_rd_en), .im_wr_en(im_wr_en), .im_wdata(im_wdata),
    .cpu_stall(cpu_stall), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  // Memory-side view: a write is captured on the negedge inside the im_wr_en cycle.
  always @(negedge clk) begin
    if (im_wr_en) begin
      wr_addr_q.push_back(im_addr);
      wr_data_q.push_back(im_wdata);
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic pulse_ld();
    @(negedge clk) ld_start = 1'b1;
    @(negedge clk) ld_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    @(negedge clk);
    rx_data = b;
    rx_rdy  = 1'b1;
    n = 0;
    while (!clr_rx_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk_eq("byte_ack", {31'd0, clr_rx_rdy}, 32'd1);
    rx_rdy = 1'b0;
  endtask

  task automatic wait_end(input int max);
    int n;
    n = 0;
    while (!(load_done || load_err) && n < max) begin
      @(negedge clk);
      n++;
    end
    chk_eq("end_reached", {31'd0, (load_done || load_err)}, 32'd1);
  endtask

  initial begin
    int base;
    cpu_addr  = 14'h0123;
    cpu_rd_en = 1'b1;
    repeat (3) @(negedge clk);
    chk_eq("rst_clr", {31'd0, clr_rx_rdy}, 32'd0);
    chk_eq("rst_wr_en", {31'd0, im_wr_en}, 32'd0);
    chk_eq("rst_wdata", im_wdata, 32'd0);
    chk_eq("rst_stall", {31'd0, cpu_stall}, 32'd0);
    chk_eq("rst_done", {31'd0, load_done}, 32'd0);
    chk_eq("rst_err", {31'd0, load_err}, 32'd0);
    rst = 1'b0;

    @(negedge clk);
    chk_eq("pt_addr", {18'd0, im_addr}, 32'h0123);
    chk_eq("pt_rd_en", {31'd0, im_rd_en}, 32'd1);
    chk_eq("pt_stall", {31'd0, cpu_stall}, 32'd0);
    chk_eq("pt_wr_en", {31'd0, im_wr_en}, 32'd0);

    // Nominal two-word load
    base = wr_cnt;
    pulse_ld();
    chk_eq("nom_stall", {31'd0, cpu_stall}, 32'd1);
    chk_eq("nom_rd_blk", {31'd0, im_rd_en}, 32'd0);
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
`ifdef IM_LOAD_CHKSUM_EN
    send_byte(8'h28);
`endif
    wait_end(20);
    chk_eq("nom_done", {31'd0, load_done}, 32'd1);
    chk_eq("nom_err", {31'd0, load_err}, 32'd0);
    chk_eq("nom_stall_off", {31'd0, cpu_stall}, 32'd0);
    repeat (2) @(negedge clk);
    chk_eq("nom_wr_cnt", wr_cnt - base, 32'd2);
    if (wr_cnt - base >= 2) begin
      chk_eq("nom_a0", {18'd0, wr_addr_q[base]}, 32'd0);
      chk_eq("nom_d0", wr_data_q[base], 32'h12345678);
      chk_eq("nom_a1", {18'd0, wr_addr_q[base+1]}, 32'd1);
      chk_eq("nom_d1", wr_data_q[base+1], 32'hDEADBEEF);
    end
    chk_eq("nom_done_sticky", {31'd0, load_done}, 32'd1);
    chk_eq("nom_pt_addr", {18'd0, im_addr}, 32'h0123);
    chk_eq("nom_pt_rd", {31'd0, im_rd_en}, 32'd1);

    // Header word count 1025 exceeds DEPTH
    base = wr_cnt;
    pulse_ld();
    chk_eq("bh_done_clr", {31'd0, load_done}, 32'd0);
    send_byte(8'h01); send_byte(8'h04);
    chk_eq("bh_err", {31'd0, load_err}, 32'd1);
    chk_eq("bh_stall", {31'd0, cpu_stall}, 32'd0);
    repeat (3) @(negedge clk);
    chk_eq("bh_no_wr", wr_cnt - base, 32'd0);
    chk_eq("bh_err_sticky", {31'd0, load_err}, 32'd1);

    // Inter-byte timeout with a partial word pending
    base = wr_cnt;
    pulse_ld();
    chk_eq("to_err_clr", {31'd0, load_err}, 32'd0);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'hAA); send_byte(8'hBB);
    repeat (int'(TMO) - 10) @(negedge clk);
    chk_eq("to_not_early", {31'd0, load_err}, 32'd0);
    chk_eq("to_still_stall", {31'd0, cpu_stall}, 32'd1);
    wait_end(40);
    chk_eq("to_err", {31'd0, load_err}, 32'd1);
    chk_eq("to_stall", {31'd0, cpu_stall}, 32'd0);
    chk_eq("to_no_wr", wr_cnt - base, 32'd0);

    // Reset during the third data byte
    base = wr_cnt;
    pulse_ld();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'hAA); send_byte(8'hBB);
    @(negedge clk);
    rx_data = 8'hCC;
    rx_rdy  = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_eq("mr_stall", {31'd0, cpu_stall}, 32'd0);
    chk_eq("mr_clr", {31'd0, clr_rx_rdy}, 32'd0);
    chk_eq("mr_wr_en", {31'd0, im_wr_en}, 32'd0);
    chk_eq("mr_wdata", im_wdata, 32'd0);
    chk_eq("mr_done", {31'd0, load_done}, 32'd0);
    chk_eq("mr_err", {31'd0, load_err}, 32'd0);
    chk_eq("mr_pt_addr", {18'd0, im_addr}, 32'h0123);
    rx_rdy = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk_eq("mr_no_wr", wr_cnt - base, 32'd0);

    base = wr_cnt;
    pulse_ld();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
`ifdef IM_LOAD_CHKSUM_EN
    send_byte(8'h45);
`endif
    wait_end(20);
    chk_eq("rl_done", {31'd0, load_done}, 32'd1);
    chk_eq("rl_err", {31'd0, load_err}, 32'd0);
    @(negedge clk);
    chk_eq("rl_wr_cnt", wr_cnt - base, 32'd1);
    if (wr_cnt - base >= 1) begin
      chk_eq("rl_a0", {18'd0, wr_addr_q[base]}, 32'd0);
      chk_eq("rl_d0", wr_data_q[base], 32'h44332211);
    end

`ifdef IM_LOAD_CHKSUM_EN
    // XOR of 01 00 11 22 33 44 is 45; a wrong checksum still leaves the word written
    base = wr_cnt;
    pulse_ld();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h46);
    wait_end(20);
    chk_eq("ck_err", {31'd0, load_err}, 32'd1);
    chk_eq("ck_done", {31'd0, load_done}, 32'd0);
    @(negedge clk);
    chk_eq("ck_wr_cnt", wr_cnt - base, 32'd1);
    if (wr_cnt - base >= 1) chk_eq("ck_d0", wr_data_q[base], 32'h44332211);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
